mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, meaning beats per read transaction (power of two, 2..16).
REQ-002 SHALL have ports: clk  in  1  clock; all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have icache ports: ic_req in 1 read request; ic_addr in 32 line address; ic_ack out 1 request accepted; ic_rvalid out 1 beat valid; ic_rlast out 1 final beat; ic_rdata out 32 beat data.
REQ-005 SHALL have dcache ports: dc_req in 1; dc_we in 1 write (single beat); dc_addr in 32; dc_wdata in 32; dc_wstrb in 4; dc_ack out 1; dc_rvalid out 1 beat valid or write done; dc_rlast out 1; dc_rdata out 32.
REQ-006 SHALL have bus ports: bus_req out 1; bus_we out 1; bus_addr out 32; bus_len out 4 (beats minus 1); bus_wdata out 32; bus_wstrb out 4; bus_gnt in 1 address accepted; bus_rvalid in 1 beat/write response; bus_rdata in 32.

Function
REQ-007 SHALL implement FSM states IDLE, ADDR, DATA; exactly one transaction outstanding.
REQ-008 IDLE: when any requester asserts req, SHALL select a winner, capture its addr/we/wdata/wstrb into registers, pulse that requester's ack for exactly one cycle, go to ADDR next cycle.
REQ-009 Arbitration SHALL be round-robin: on simultaneous ic_req and dc_req, the requester not granted last wins; after reset dcache has priority.
REQ-010 Single requester in IDLE SHALL be granted regardless of round-robin pointer; pointer updates to the winner on every grant.
REQ-011 Requesters SHALL hold req and payload stable until ack; arbiter samples payload only in the ack cycle; req seen in the cycle after ack is a new request.
REQ-012 ADDR: bus_req=1 with registered payload; bus_len=LINE_WORDS-1 for icache and dcache reads, 0 for dcache writes; bus_wdata/bus_wstrb zero for reads; advance to DATA on the cycle bus_gnt=1.
REQ-013 bus_req, bus_we, bus_addr, bus_len, bus_wdata, bus_wstrb SHALL be register-driven and stable throughout ADDR; bus_req=0 in IDLE and DATA.
REQ-014 DATA: beat counter (log2 LINE_WORDS bits) SHALL start at 0, increment per bus_rvalid; each bus_rvalid forwarded combinationally to the owner's rvalid with rdata=bus_rdata, same cycle.
REQ-015 rlast SHALL assert with the beat where counter==bus_len (LINE_WORDS-th beat for reads, first response for writes); FSM returns to IDLE next cycle.
REQ-016 Non-owner rvalid/rlast SHALL be 0; rdata outputs SHALL be bus_rdata when rvalid else 0.
REQ-017 No new grant SHALL occur in the rlast cycle; earliest next ack is the cycle after return to IDLE.
REQ-018 bus_rvalid in IDLE or ADDR SHALL be ignored (no output, no state change).
REQ-019 bus_gnt outside ADDR SHALL be ignored.
REQ-020 Dcache write with dc_wstrb=0 SHALL still perform a full bus transaction.

Reset
REQ-021 Asserting rst at any time, including mid-transaction, SHALL immediately force IDLE, counter 0, round-robin pointer to dcache-priority, all outputs 0 (ack, rvalid, rlast, bus_req, bus_we, bus_addr, bus_len, bus_wdata, bus_wstrb, rdata).
REQ-022 An aborted transaction SHALL NOT be resumed after rst release; the first grant is evaluated in the first clk edge with rst low.

Verification
REQ-023 Reset release, dc_req=1 dc_we=0 addr 0x1000 and ic_req=1 addr 0x2000 same cycle -> dc_ack pulse, bus_addr=0x1000 bus_len=3; after 4 bus_rvalid dc_rlast on 4th; then ic_ack, bus_addr=0x2000.
REQ-024 Both requests continuously asserted for 4 transactions -> grant order dc, ic, dc, ic.
REQ-025 dc write addr 0x80 wdata 0xDEADBEEF wstrb 0xF, bus_gnt delayed 3 cycles -> bus_req held 3 cycles with stable payload, bus_len=0, bus_we=1; single bus_rvalid gives dc_rvalid=dc_rlast=1.
REQ-026 Icache read, rst pulsed after 2 of 4 beats -> all outputs 0 immediately; stray bus_rvalid after release produces no ic_rvalid; new ic_req granted normally.
REQ-027 Spurious bus_rvalid and bus_gnt in IDLE -> no rvalid, no state change; ic_rdata/dc_rdata remain 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester (icache/dcache) round-robin arbiter onto a single-outstanding
// memory bus. Reads return LINE_WORDS beats; dcache writes are single-beat.
module mem_bus_arbiter #(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_ack,
    output logic        ic_rvalid,
    output logic        ic_rlast,
    output logic [31:0] ic_rdata,

    input  logic        dc_req,
    input  logic        dc_we,
    input  logic [31:0] dc_addr,
    input  logic [31:0] dc_wdata,
    input  logic [3:0]  dc_wstrb,
    output logic        dc_ack,
    output logic        dc_rvalid,
    output logic        dc_rlast,
    output logic [31:0] dc_rdata,

    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_len,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CNT_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [3:0]  READ_LEN = 4'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               last_dc_q;   // 1: dcache won the most recent grant
    logic               owner_dc_q;  // 1: current transaction belongs to dcache
    logic [CNT_W-1:0]   beat_q;

    logic               grant_c;
    logic               win_dc_c;
    logic               beat_c;
    logic               last_beat_c;
    logic               win_we_c;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, arbitration and beat qualification.
    always_comb begin
        state_d     = state_q;
        grant_c     = 1'b0;
        beat_c      = 1'b0;
        last_beat_c = 1'b0;
        // dcache wins unless icache is also asking and dcache had the last turn
        win_dc_c    = dc_req && (!ic_req || !last_dc_q);
        win_we_c    = win_dc_c && dc_we;

        unique case (state_q)
            IDLE: begin
                if (!rst && (ic_req || dc_req)) begin
                    grant_c = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (bus_gnt) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus_rvalid) begin
                    beat_c = 1'b1;
                    if (4'(beat_q) == bus_len) begin
                        last_beat_c = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant capture, bus request payload, and beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dc_q  <= 1'b0;
            owner_dc_q <= 1'b0;
            beat_q     <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_len    <= '0;
            bus_wdata  <= '0;
            bus_wstrb  <= '0;
        end else begin
            if (grant_c) begin
                last_dc_q  <= win_dc_c;
                owner_dc_q <= win_dc_c;
                beat_q     <= '0;
                bus_req    <= 1'b1;
                bus_we     <= win_we_c;
                bus_addr   <= win_dc_c ? dc_addr : ic_addr;
                bus_len    <= win_we_c ? 4'd0 : READ_LEN;
                bus_wdata  <= win_we_c ? dc_wdata : 32'd0;
                bus_wstrb  <= win_we_c ? dc_wstrb : 4'd0;
            end else if (state_q == ADDR && bus_gnt) begin
                bus_req <= 1'b0;
            end

            if (beat_c) begin
                beat_q <= last_beat_c ? '0 : beat_q + CNT_W'(1);
            end
        end
    end

    // Requester-side handshake and same-cycle beat forwarding.
    always_comb begin
        ic_ack    = grant_c && !win_dc_c;
        dc_ack    = grant_c && win_dc_c;
        ic_rvalid = beat_c && !owner_dc_q;
        ic_rlast  = last_beat_c && !owner_dc_q;
        dc_rvalid = beat_c && owner_dc_q;
        dc_rlast  = last_beat_c && owner_dc_q;
        ic_rdata  = ic_rvalid ? bus_rdata : 32'd0;
        dc_rdata  = dc_rvalid ? bus_rdata : 32'd0;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table of arbitration transactions plus
// hand-written reset/spurious-input sequences; beats checked via scoreboard.
module tb_mem_bus_arbiter;

    localparam int unsigned LINE_WORDS = 4;

    logic        clk;
    logic        rst;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_ack, ic_rvalid, ic_rlast;
    logic [31:0] ic_rdata;
    logic        dc_req, dc_we;
    logic [31:0] dc_addr, dc_wdata;
    logic [3:0]  dc_wstrb;
    logic        dc_ack, dc_rvalid, dc_rlast;
    logic [31:0] dc_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_len;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ic_req;
        logic        dc_req;
        logic        dc_we;
        logic [31:0] ic_addr;
        logic [31:0] dc_addr;
        logic [31:0] dc_wdata;
        logic [3:0]  dc_wstrb;
        int          gnt_delay;
        logic        exp_dc;
        logic [3:0]  exp_len;
    } vec_t;

    typedef struct {
        logic        dc;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    vec_t  vecs[12];

    mem_bus_arbiter #(.LINE_WORDS(LINE_WORDS)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack),
        .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_wstrb(dc_wstrb), .dc_ack(dc_ack), .dc_rvalid(dc_rvalid),
        .dc_rlast(dc_rlast), .dc_rdata(dc_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_len(bus_len),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ":ic_ack"},    32'(ic_ack),    32'd0);
        chk({tag, ":ic_rvalid"}, 32'(ic_rvalid), 32'd0);
        chk({tag, ":ic_rlast"},  32'(ic_rlast),  32'd0);
        chk({tag, ":ic_rdata"},  ic_rdata,       32'd0);
        chk({tag, ":dc_ack"},    32'(dc_ack),    32'd0);
        chk({tag, ":dc_rvalid"}, 32'(dc_rvalid), 32'd0);
        chk({tag, ":dc_rlast"},  32'(dc_rlast),  32'd0);
        chk({tag, ":dc_rdata"},  dc_rdata,       32'd0);
        chk({tag, ":bus_req"},   32'(bus_req),   32'd0);
        chk({tag, ":bus_we"},    32'(bus_we),    32'd0);
        chk({tag, ":bus_addr"},  bus_addr,       32'd0);
        chk({tag, ":bus_len"},   32'(bus_len),   32'd0);
        chk({tag, ":bus_wdata"}, bus_wdata,      32'd0);
        chk({tag, ":bus_wstrb"}, 32'(bus_wstrb), 32'd0);
    endtask

    // One complete transaction: request cycle, address phase, data beats.
    task automatic do_txn(input vec_t v);
        logic [31:0] exp_addr, exp_wdata;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
        int          beats;
        cyc();
        bus_rvalid = 1'b0;
        bus_gnt    = 1'b0;
        ic_req     = v.ic_req;
        ic_addr    = v.ic_addr;
        dc_req     = v.dc_req;
        dc_we      = v.dc_we;
        dc_addr    = v.dc_addr;
        dc_wdata   = v.dc_wdata;
        dc_wstrb   = v.dc_wstrb;
        @(negedge clk);
        chk("dc_ack", 32'(dc_ack), 32'(v.exp_dc));
        chk("ic_ack", 32'(ic_ack), 32'(!v.exp_dc));

        exp_addr  = v.exp_dc ? v.dc_addr : v.ic_addr;
        exp_we    = v.exp_dc && v.dc_we;
        exp_wdata = exp_we ? v.dc_wdata : 32'd0;
        exp_wstrb = exp_we ? v.dc_wstrb : 4'd0;

        // winner drops req and changes its payload; bus must keep the captured copy
        cyc();
        if (v.exp_dc) begin
            dc_req   = 1'b0;
            dc_we    = ~dc_we;
            dc_addr  = $urandom;
            dc_wdata = $urandom;
            dc_wstrb = 4'($urandom);
        end else begin
            ic_req  = 1'b0;
            ic_addr = $urandom;
        end
        for (int d = 0; d <= v.gnt_delay; d++) begin
            if (d > 0) cyc();
            bus_gnt    = (d == v.gnt_delay);
            bus_rvalid = (d == 0);  // stray response during address phase
            bus_rdata  = $urandom;
            @(negedge clk);
            chk("addr_bus_req",   32'(bus_req),   32'd1);
            chk("addr_bus_addr",  bus_addr,       exp_addr);
            chk("addr_bus_len",   32'(bus_len),   32'(v.exp_len));
            chk("addr_bus_we",    32'(bus_we),    32'(exp_we));
            chk("addr_bus_wdata", bus_wdata,      exp_wdata);
            chk("addr_bus_wstrb", 32'(bus_wstrb), 32'(exp_wstrb));
            chk("addr_no_ack",    32'(ic_ack | dc_ack), 32'd0);
        end

        beats = int'(v.exp_len) + 1;
        for (int b = 0; b < beats; b++) begin
            cyc();
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b1;
            bus_rdata  = $urandom;
            sb.push_back('{v.exp_dc, bus_rdata, (b == beats - 1)});
            @(negedge clk);
            if (b == 0) chk("data_bus_req", 32'(bus_req), 32'd0);
            if (b == beats - 1) chk("rlast_no_ack", 32'(ic_ack | dc_ack), 32'd0);
        end
    endtask

    // Scoreboard: every forwarded beat must match the next expected one.
    always @(negedge clk) begin
        if (ic_rvalid || dc_rvalid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat ic_rvalid=%0b dc_rvalid=%0b at %0t",
                         ic_rvalid, dc_rvalid, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("beat_dc_rvalid", 32'(dc_rvalid), 32'(mon_e.dc));
                chk("beat_ic_rvalid", 32'(ic_rvalid), 32'(!mon_e.dc));
                chk("beat_rdata", mon_e.dc ? dc_rdata : ic_rdata, mon_e.data);
                chk("beat_rlast", 32'(mon_e.dc ? dc_rlast : ic_rlast), 32'(mon_e.last));
                chk("beat_other_rdata", mon_e.dc ? ic_rdata : dc_rdata, 32'd0);
            end
        end else begin
            chk("idle_rdata", ic_rdata | dc_rdata, 32'd0);
            chk("idle_rlast", 32'(ic_rlast | dc_rlast), 32'd0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //            ic dc we   ic_addr       dc_addr       wdata          wstrb dly dc   len
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h2000, 32'h1000, 32'h0,        4'h0, 0, 1'b1, 4'd3};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h2000, 32'h0,    32'h0,        4'h0, 1, 1'b0, 4'd3};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h2100, 32'h1100, 32'h0,        4'h0, 0, 1'b1, 4'd3};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h2100, 32'h1200, 32'h0,        4'h0, 2, 1'b0, 4'd3};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h2200, 32'h1200, 32'h0,        4'h0, 0, 1'b1, 4'd3};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h2200, 32'h80,   32'hDEADBEEF, 4'hF, 0, 1'b0, 4'd3};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h0,    32'h80,   32'hDEADBEEF, 4'hF, 3, 1'b1, 4'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h2300, 32'h0,    32'h0,        4'h0, 1, 1'b0, 4'd3};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h0,    32'h90,   32'h12345678, 4'h0, 0, 1'b1, 4'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,    32'h1300, 32'h0,        4'h0, 0, 1'b1, 4'd3};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h2400, 32'h1400, 32'h0,        4'h0, 0, 1'b0, 4'd3};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,    32'h1400, 32'h0,        4'h0, 0, 1'b1, 4'd3};

        rst = 1'b1;
        ic_req = 1'b1; ic_addr = 32'h2000;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h1000; dc_wdata = '0; dc_wstrb = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        check_all_zero("reset");
        cyc();
        ic_req = 1'b0; dc_req = 1'b0; bus_rvalid = 1'b0;
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i]);
        end

        // reset in the middle of an icache read
        cyc();
        bus_rvalid = 1'b0;
        ic_req = 1'b1; ic_addr = 32'h3000; dc_req = 1'b0;
        @(negedge clk);
        chk("abort_ic_ack", 32'(ic_ack), 32'd1);
        cyc();
        ic_req = 1'b0; bus_gnt = 1'b1;
        @(negedge clk);
        chk("abort_bus_addr", bus_addr, 32'h3000);
        for (int b = 0; b < 2; b++) begin
            cyc();
            bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = $urandom;
            sb.push_back('{1'b0, bus_rdata, 1'b0});
            @(negedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        cyc();
        bus_rvalid = 1'b0;
        cyc();
        rst = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = $urandom;
        @(negedge clk);
        chk("stray_ic_rvalid", 32'(ic_rvalid), 32'd0);
        chk("stray_bus_req", 32'(bus_req), 32'd0);
        do_txn('{1'b1, 1'b0, 1'b0, 32'h4000, 32'h0, 32'h0, 4'h0, 0, 1'b0, 4'd3});

        // dcache gets the last grant, then reset must restore dcache priority
        do_txn('{1'b0, 1'b1, 1'b0, 32'h0, 32'h5000, 32'h0, 4'h0, 0, 1'b1, 4'd3});
        cyc();
        bus_rvalid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        do_txn('{1'b1, 1'b1, 1'b0, 32'h6000, 32'h7000, 32'h0, 4'h0, 0, 1'b1, 4'd3});
        do_txn('{1'b1, 1'b0, 1'b0, 32'h6000, 32'h0, 32'h0, 4'h0, 0, 1'b0, 4'd3});

        // spurious bus responses and grants while idle
        cyc();
        ic_req = 1'b0; dc_req = 1'b0;
        bus_rvalid = 1'b1; bus_gnt = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("spur_ic_rdata", ic_rdata, 32'd0);
        chk("spur_dc_rdata", dc_rdata, 32'd0);
        chk("spur_bus_req", 32'(bus_req), 32'd0);
        cyc();
        bus_rvalid = 1'b0; bus_gnt = 1'b0;
        @(negedge clk);
        chk("spur_bus_req2", 32'(bus_req), 32'd0);
        do_txn('{1'b0, 1'b1, 1'b1, 32'h0, 32'hC0, 32'hCAFEF00D, 4'h3, 1, 1'b1, 4'd0});

        cyc();
        bus_rvalid = 1'b0; bus_gnt = 1'b0; ic_req = 1'b0; dc_req = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("final_bus_req", 32'(bus_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
